// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, constants and helpers for the 4x4 keypad scanner.
//   state_e        : scanner FSM states (SCAN, DEBOUNCE, HELD)
//   NUM_ROWS/COLS  : keypad matrix geometry
//   ROW_IDLE       : row pattern with no key pulling any row low
//   row_dec_t      : decoded row sample (single-low flag + row index)
//   row_onehot_idx : decode a synchronized active-low row sample
//   col_drive      : active-low column drive pattern for a column index
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  localparam logic [NUM_ROWS-1:0] ROW_IDLE = 4'b1111;

  typedef struct packed {
    logic       single_low;
    logic [1:0] idx;
  } row_dec_t;

  // Only a sample with exactly one row low names a key; zero-low and
  // multi-low (ghosting / two keys in one column) both decode as "no key".
  function automatic row_dec_t row_onehot_idx(input logic [NUM_ROWS-1:0] row);
    row_dec_t r;
    r.single_low = 1'b0;
    r.idx        = 2'd0;
    case (row)
      4'b1110: begin r.single_low = 1'b1; r.idx = 2'd0; end
      4'b1101: begin r.single_low = 1'b1; r.idx = 2'd1; end
      4'b1011: begin r.single_low = 1'b1; r.idx = 2'd2; end
      4'b0111: begin r.single_low = 1'b1; r.idx = 2'd3; end
      default: begin r.single_low = 1'b0; r.idx = 2'd0; end
    endcase
    return r;
  endfunction

  function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs.
//   clk   : destination clock
//   reset : synchronous active-high reset; both stages reset to all-ones
//           so the active-low keypad rows read as idle out of reset
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles behind d
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning 4x4 matrix keypad reader with debounce,
// a one-entry holding register behind a valid/ready handshake, and a
// history of the last 8 accepted keys.
//   clk         : system clock
//   reset       : synchronous active-high reset
//   row_n       : keypad rows, active-low, asynchronous
//   col_n       : column drive, active-low, exactly one bit low
//   key_code    : accepted key = {row_idx, col_idx}
//   key_valid   : key_code holds an unconsumed key
//   key_ready   : consumer takes key_code when key_valid & key_ready
//   overrun     : sticky, a key was dropped because key_code was full
//   key_held    : high from press acceptance until release acceptance
//   key_history : last 8 accepted codes, newest in [3:0]
//   state_dbg   : current FSM state (keypad_pkg::state_e encoding)
//
// Handshake: key_valid rises the cycle after a key is accepted and stays
// high until an edge with key_valid & key_ready. An accepting edge that
// coincides with a handshake reloads the register and keeps key_valid
// high; an accepting edge with key_valid high and no handshake drops the
// new key and sets overrun. A handshake clears overrun.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 4,  // cycles per column, >= 4
  parameter int DEBOUNCE_CNT = 3   // identical ticks for press/release, >= 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ready,
  output logic        overrun,
  output logic        key_held,
  output logic [31:0] key_history,
  output logic [1:0]  state_dbg
);

  localparam int DW    = $clog2(SCAN_DIV);
  localparam int STB_W = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [DW-1:0]    DWELL_LAST = DW'(SCAN_DIV - 1);
  // The stable counter holds the number of matching ticks seen so far;
  // the tick that would bring it to DEBOUNCE_CNT is the accepting one.
  localparam logic [STB_W-1:0] STB_LAST   = STB_W'(DEBOUNCE_CNT - 1);

  // ---------------------------------------------------------------------
  // Row synchronizer
  // ---------------------------------------------------------------------
  logic [3:0] row_s;

  sync_2ff #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_n),
    .q     (row_s)
  );

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e            state_q;
  logic [DW-1:0]     dwell_q;
  logic [STB_W-1:0]  stable_q;
  logic [1:0]        col_idx_q;
  logic [3:0]        col_n_q;
  logic [1:0]        cap_row_q;
  logic [3:0]        cap_pat_q;
  logic [3:0]        key_code_q;
  logic              key_valid_q;
  logic              overrun_q;
  logic              key_held_q;
  logic [31:0]       key_history_q;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic       tick;
  row_dec_t   dec;
  logic [1:0] col_next;
  logic       accept;
  logic [3:0] acc_code;
  logic       handshake;

  assign tick      = (dwell_q == DWELL_LAST);
  assign dec       = row_onehot_idx(row_s);
  assign col_next  = col_idx_q + 2'd1;
  assign handshake = key_valid_q & key_ready;

  // accept marks the tick on which a press is debounced. The column is
  // frozen from detection onwards, so col_idx_q is the key's column.
  always_comb begin
    accept   = 1'b0;
    acc_code = {dec.idx, col_idx_q};
    case (state_q)
      SCAN: begin
        if (tick && dec.single_low && (DEBOUNCE_CNT == 1)) begin
          accept   = 1'b1;
          acc_code = {dec.idx, col_idx_q};
        end
      end
      DEBOUNCE: begin
        if (tick && (row_s == cap_pat_q) && (stable_q == STB_LAST)) begin
          accept   = 1'b1;
          acc_code = {cap_row_q, col_idx_q};
        end
      end
      default: begin
        accept   = 1'b0;
        acc_code = {dec.idx, col_idx_q};
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Dwell counter, scan FSM and output register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SCAN;
      dwell_q       <= '0;
      stable_q      <= '0;
      col_idx_q     <= 2'd0;
      col_n_q       <= 4'b1110;
      cap_row_q     <= 2'd0;
      cap_pat_q     <= ROW_IDLE;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      key_held_q    <= 1'b0;
      key_history_q <= 32'd0;
    end else begin
      // Free-running dwell: every column gets exactly SCAN_DIV cycles
      // because the column only ever changes on the tick cycle.
      if (tick) begin
        dwell_q <= '0;
      end else begin
        dwell_q <= dwell_q + DW'(1);
      end

      case (state_q)
        SCAN: begin
          if (tick) begin
            if (dec.single_low) begin
              cap_row_q <= dec.idx;
              cap_pat_q <= row_s;
              if (DEBOUNCE_CNT == 1) begin
                state_q    <= HELD;
                key_held_q <= 1'b1;
                stable_q   <= '0;
              end else begin
                state_q  <= DEBOUNCE;
                stable_q <= STB_W'(1);
              end
            end else begin
              col_idx_q <= col_next;
              col_n_q   <= col_drive(col_next);
            end
          end
        end

        DEBOUNCE: begin
          if (tick) begin
            if (row_s == cap_pat_q) begin
              if (stable_q == STB_LAST) begin
                state_q    <= HELD;
                key_held_q <= 1'b1;
                stable_q   <= '0;
              end else begin
                stable_q <= stable_q + STB_W'(1);
              end
            end else begin
              // Bounce or early release: resume scanning at the next column.
              state_q   <= SCAN;
              stable_q  <= '0;
              col_idx_q <= col_next;
              col_n_q   <= col_drive(col_next);
            end
          end
        end

        HELD: begin
          // stable_q now counts consecutive idle ticks toward release.
          if (tick) begin
            if (row_s == ROW_IDLE) begin
              if (stable_q == STB_LAST) begin
                state_q    <= SCAN;
                key_held_q <= 1'b0;
                stable_q   <= '0;
                col_idx_q  <= col_next;
                col_n_q    <= col_drive(col_next);
              end else begin
                stable_q <= stable_q + STB_W'(1);
              end
            end else begin
              stable_q <= '0;
            end
          end
        end

        default: begin
          state_q  <= SCAN;
          stable_q <= '0;
        end
      endcase

      // Holding register: a handshake on the accepting edge frees the slot
      // in time for the new key, so the key is loaded rather than dropped.
      if (accept) begin
        if (!key_valid_q || handshake) begin
          key_code_q    <= acc_code;
          key_valid_q   <= 1'b1;
          key_history_q <= {key_history_q[27:0], acc_code};
          if (handshake) begin
            overrun_q <= 1'b0;
          end
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (handshake) begin
        key_valid_q <= 1'b0;
        overrun_q   <= 1'b0;
      end
    end
  end

  assign col_n       = col_n_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign overrun     = overrun_q;
  assign key_held    = key_held_q;
  assign key_history = key_history_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a behavioural
// keypad model (a pressed key shorts its row to its column when that
// column is driven low).
module tb_keypad_scanner;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;

  logic        clk;
  logic        reset;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        overrun;
  logic        key_held;
  logic [31:0] key_history;
  logic [1:0]  state_dbg;

  int n_vec;
  int n_err;

  // Keypad model: two independent "fingers".
  logic       k1_en, k2_en;
  logic [1:0] k1_r, k1_c, k2_r, k2_c;

  always_comb begin
    row_n = 4'b1111;
    if (k1_en && !col_n[k1_c]) row_n[k1_r] = 1'b0;
    if (k2_en && !col_n[k2_c]) row_n[k2_r] = 1'b0;
  end

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .overrun     (overrun),
    .key_held    (key_held),
    .key_history (key_history),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic press1(input logic [1:0] r, input logic [1:0] c);
    k1_r  = r;
    k1_c  = c;
    k1_en = 1'b1;
  endtask

  task automatic wait_state(input string tag, input logic [1:0] target, input int budget);
    int i;
    i = 0;
    while (state_dbg !== target && i < budget) begin
      step(1);
      i++;
    end
    check(tag, 32'(state_dbg), 32'(target));
  endtask

  task automatic wait_held(input string tag, input logic val, input int budget);
    int i;
    i = 0;
    while (key_held !== val && i < budget) begin
      step(1);
      i++;
    end
    check(tag, 32'(key_held), 32'(val));
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_col"},   32'(col_n),     32'h0000_000E);
    check({pfx, "_code"},  32'(key_code),  32'h0);
    check({pfx, "_valid"}, 32'(key_valid), 32'h0);
    check({pfx, "_ovr"},   32'(overrun),   32'h0);
    check({pfx, "_held"},  32'(key_held),  32'h0);
    check({pfx, "_hist"},  key_history,    32'h0);
    check({pfx, "_state"}, 32'(state_dbg), 32'(ST_SCAN));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus / scoreboard ----------------
  logic [3:0] exp_cols [4];

  initial begin
    int left_scan;
    int col_changes;
    logic [3:0] prev_col;

    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b1;
    key_ready = 1'b0;
    k1_en     = 1'b0;
    k2_en     = 1'b0;
    k1_r = 2'd0; k1_c = 2'd0; k2_r = 2'd0; k2_c = 2'd0;
    exp_cols[0] = 4'b1110;
    exp_cols[1] = 4'b1101;
    exp_cols[2] = 4'b1011;
    exp_cols[3] = 4'b0111;

    // 1: reset values, then idle column rotation (4 cycles per column)
    step(3);
    check_reset_vals("rst");
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      check("idle_col", 32'(col_n), 32'(exp_cols[(i / 4) % 4]));
      step(1);
    end
    check("idle_valid", 32'(key_valid), 32'h0);
    check("idle_hist",  key_history,    32'h0);

    // 2: key (row 2, col 1) = 4'h9, consumer always ready
    key_ready = 1'b1;
    press1(2'd2, 2'd1);
    wait_state("t2_detect", ST_DEBOUNCE, 40);
    step(7);
    check("t2_valid_early", 32'(key_valid), 32'h0);
    step(1);
    check("t2_valid",  32'(key_valid), 32'h1);
    check("t2_code",   32'(key_code),  32'h9);
    check("t2_hist",   key_history,    32'h0000_0009);
    check("t2_held",   32'(key_held),  32'h1);
    step(1);
    check("t2_consumed", 32'(key_valid), 32'h0);
    step(25);
    check("t2_still_held", 32'(key_held), 32'h1);
    k1_en = 1'b0;
    step(10);
    check("t2_release_wait", 32'(key_held), 32'h1);
    step(6);
    check("t2_released", 32'(key_held),  32'h0);
    check("t2_scan",     32'(state_dbg), 32'(ST_SCAN));
    check("t2_hist_end", key_history,    32'h0000_0009);

    // 3: bounce - low for one tick, released across the next tick
    press1(2'd1, 2'd3);
    wait_state("t3_detect", ST_DEBOUNCE, 40);
    k1_en = 1'b0;
    step(4);
    check("t3_bounce_scan",  32'(state_dbg), 32'(ST_SCAN));
    check("t3_bounce_valid", 32'(key_valid), 32'h0);
    check("t3_bounce_hist",  key_history,    32'h0000_0009);
    press1(2'd1, 2'd3);
    wait_held("t3_held", 1'b1, 60);
    check("t3_valid", 32'(key_valid), 32'h1);
    check("t3_code",  32'(key_code),  32'h7);
    check("t3_ovr",   32'(overrun),   32'h0);
    k1_en = 1'b0;
    wait_held("t3_rel", 1'b0, 30);
    check("t3_hist", key_history, 32'h0000_0097);

    // 4: overrun - consumer stalled, second key dropped
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    key_ready = 1'b0;
    press1(2'd2, 2'd1);
    wait_held("t4_held_a", 1'b1, 60);
    check("t4_code_a", 32'(key_code), 32'h9);
    k1_en = 1'b0;
    wait_held("t4_rel_a", 1'b0, 30);
    press1(2'd0, 2'd2);
    wait_held("t4_held_b", 1'b1, 60);
    check("t4_code_kept", 32'(key_code),  32'h9);
    check("t4_ovr",       32'(overrun),   32'h1);
    check("t4_valid",     32'(key_valid), 32'h1);
    check("t4_hist",      key_history,    32'h0000_0009);
    k1_en = 1'b0;
    wait_held("t4_rel_b", 1'b0, 30);
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    check("t4_hs_valid", 32'(key_valid), 32'h0);
    check("t4_hs_ovr",   32'(overrun),   32'h0);
    check("t4_hs_code",  32'(key_code),  32'h9);

    // 5a: rows 0 and 3 low in column 2 - ignored, scanning continues
    press1(2'd0, 2'd2);
    k2_r = 2'd3; k2_c = 2'd2; k2_en = 1'b1;
    left_scan   = 0;
    col_changes = 0;
    prev_col    = col_n;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (state_dbg != ST_SCAN) left_scan++;
      if (col_n != prev_col) col_changes++;
      prev_col = col_n;
    end
    check("t5_multi_stay", 32'(left_scan), 32'h0);
    check("t5_multi_scanning", 32'(col_changes >= 8), 32'h1);
    check("t5_multi_valid", 32'(key_valid), 32'h0);
    k1_en = 1'b0;
    k2_en = 1'b0;

    // 5b: load C, drop 0 (overrun), then accept 6 on a handshake edge
    press1(2'd3, 2'd0);
    wait_held("t5_held_c", 1'b1, 60);
    check("t5_code_c", 32'(key_code), 32'hC);
    k1_en = 1'b0;
    wait_held("t5_rel_c", 1'b0, 30);
    press1(2'd0, 2'd0);
    wait_held("t5_held_0", 1'b1, 60);
    check("t5_ovr_set", 32'(overrun), 32'h1);
    k1_en = 1'b0;
    wait_held("t5_rel_0", 1'b0, 30);
    press1(2'd1, 2'd2);
    wait_state("t5_detect_6", ST_DEBOUNCE, 40);
    step(7);
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    check("t5_coinc_valid", 32'(key_valid), 32'h1);
    check("t5_coinc_code",  32'(key_code),  32'h6);
    check("t5_coinc_ovr",   32'(overrun),   32'h0);
    check("t5_coinc_hist",  key_history,    32'h0000_09C6);
    step(1);
    check("t5_valid_kept", 32'(key_valid), 32'h1);
    k1_en = 1'b0;
    wait_held("t5_rel_6", 1'b0, 30);

    // 6a: reset during DEBOUNCE
    press1(2'd2, 2'd1);
    wait_state("t6_detect", ST_DEBOUNCE, 40);
    reset = 1'b1;
    step(1);
    k1_en = 1'b0;
    check_reset_vals("t6_deb");
    reset = 1'b0;
    step(40);
    check("t6_deb_valid", 32'(key_valid), 32'h0);
    check("t6_deb_hist",  key_history,    32'h0);

    // 6b: reset during HELD
    press1(2'd1, 2'd1);
    wait_held("t6_held", 1'b1, 60);
    check("t6_held_code", 32'(key_code), 32'h5);
    reset = 1'b1;
    step(1);
    k1_en = 1'b0;
    check_reset_vals("t6_hld");
    reset = 1'b0;
    step(40);
    check("t6_hld_valid", 32'(key_valid), 32'h0);
    check("t6_hld_held",  32'(key_held),  32'h0);
    check("t6_hld_hist",  key_history,    32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
